truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Sequential, self-checking vector source and response checker for small combinational gate circuits.
- It replaces hand-written timed stimulus blocks: it steps through every input combination, holds each for a settle window, and samples the circuit output.
- It compares the sample against a parameterised expected truth table and reports pass/fail, the error count and the first failing vector.
- It sits between a control source (START) and the combinational circuit under test.

Parameters:
- N_IN, 3, number of circuit inputs; the vector space is 2^N_IN.
- SETTLE, 4, clock cycles each vector is held before Z is sampled; minimum 1.
- EXPECT, 8'hB7, expected Z per vector index (bit i = expected Z for VEC==i); width 2^N_IN. Default is Z = (A&B) ^ ~(B&C), with {A,B,C} = VEC[2:0].

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  request a full sweep; sampled only in IDLE.
- VEC  output  N_IN  vector driven to the circuit; MSB is A.
- Z  input  1  circuit response.
- BUSY  output  1  high while a sweep is in progress.
- DONE  output  1  one-cycle pulse at sweep completion.
- PASS  output  1  set at completion when ERR_COUNT==0.
- ERR_COUNT  output  N_IN+1  number of mismatching vectors; holds up to 2^N_IN.
- FIRST_FAIL  output  N_IN  index of the first mismatching vector.
- FAIL_SEEN  output  1  at least one mismatch in the current or last sweep.

Behaviour:
- Reset (RESET_N=0, asynchronous, takes effect at any time including mid-sweep):
  - State IDLE.
  - VEC=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FIRST_FAIL=0, FAIL_SEEN=0.
  - Settle counter 0.
- FSM states:
  - IDLE: BUSY=0. On an edge with START=1: VEC<=0, ERR_COUNT<=0, FAIL_SEEN<=0, FIRST_FAIL<=0, PASS<=0, settle counter<=SETTLE-1, BUSY<=1, go to HOLD.
  - HOLD: the counter decrements each edge. On the edge where the counter==0, Z is sampled and compared to EXPECT[VEC].
  - On a mismatch: ERR_COUNT<=ERR_COUNT+1. If FAIL_SEEN==0, FIRST_FAIL<=VEC and FAIL_SEEN<=1.
  - Same edge, if VEC != 2^N_IN-1: VEC<=VEC+1, counter<=SETTLE-1, stay in HOLD.
  - Same edge, if VEC == 2^N_IN-1: go to IDLE, BUSY<=0, DONE<=1, PASS<=(final error count==0). The final mismatch is included. VEC holds its last value.
- Latency: DONE rises exactly 2^N_IN*SETTLE edges after the START-accepting edge (32 with defaults). Each vector is held exactly SETTLE cycles.
- DONE is high for exactly one cycle and clears on the following edge.
- START while BUSY=1 is ignored; there is no queueing.
- START=1 in the IDLE cycle where DONE=1 is accepted and starts a new sweep; results are cleared at that edge.
- START held high continuously gives back-to-back sweeps with one IDLE cycle between them.
- Results (PASS, ERR_COUNT, FIRST_FAIL, FAIL_SEEN) hold until the next accepted START or reset.
- ERR_COUNT cannot overflow: the maximum is 2^N_IN, which fits N_IN+1 bits.
- X/Z on the Z input is counted as a mismatch: the comparison uses case inequality.

Test Plan:
- Reset values: assert RESET_N=0 with START=1 -> all outputs 0, VEC=3'b000, no sweep starts; release and hold START=0 -> stays IDLE.
- Golden sweep, Z driven by a correct model of (A&B)^~(B&C), START for one cycle -> VEC steps 0..7 every 4 cycles; DONE pulses 32 edges after START; PASS=1, ERR_COUNT=0, FAIL_SEEN=0.
- Z stuck-at-0 -> ERR_COUNT=6, FIRST_FAIL=3'd0, FAIL_SEEN=1, PASS=0.
- Z inverted only for VEC=6 -> ERR_COUNT=1, FIRST_FAIL=3'd6, PASS=0.
- START pulsed again at cycle 10 of a sweep -> ignored; DONE still at edge 32. START held through DONE -> new sweep begins, results cleared, BUSY=1 next cycle.
- RESET_N low for 1 cycle mid-sweep (VEC=3) -> immediately VEC=0, BUSY=0, ERR_COUNT=0. Then START with SETTLE=1 (separate elaboration) -> DONE after 8 edges, PASS=1.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// Connection bundle between the truth-table checker, its control source and
// the combinational circuit under test.
//   START      : sweep request from the control source
//   VEC        : input vector driven to the circuit (MSB is A)
//   Z          : circuit response
//   BUSY/DONE  : sweep in progress / one-cycle completion pulse
//   PASS, ERR_COUNT, FIRST_FAIL, FAIL_SEEN : sweep results
interface truth_table_checker_if #(
    parameter int unsigned N_IN = 3
);
    logic            START;
    logic [N_IN-1:0] VEC;
    logic            Z;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [N_IN:0]   ERR_COUNT;
    logic [N_IN-1:0] FIRST_FAIL;
    logic            FAIL_SEEN;

    // Checker side
    modport master (
        input  START,
        input  Z,
        output VEC,
        output BUSY,
        output DONE,
        output PASS,
        output ERR_COUNT,
        output FIRST_FAIL,
        output FAIL_SEEN
    );

    // Control source / circuit side
    modport slave (
        output START,
        output Z,
        input  VEC,
        input  BUSY,
        input  DONE,
        input  PASS,
        input  ERR_COUNT,
        input  FIRST_FAIL,
        input  FAIL_SEEN
    );
endinterface

// File: rtl/truth_table_checker.sv
// Sequential vector source and response checker for a small combinational
// circuit. On START it walks VEC through every input combination, holds each
// for SETTLE cycles, samples Z on the last cycle and compares it with EXPECT.
//   CLK      : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : START/Z in, VEC/BUSY/DONE/PASS/ERR_COUNT/FIRST_FAIL/FAIL_SEEN out
module truth_table_checker #(
    parameter int unsigned              N_IN   = 3,
    parameter int unsigned              SETTLE = 4,
    parameter logic [(1 << N_IN)-1:0]   EXPECT = 8'hB7
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    truth_table_checker_if.master   bus
);

    localparam int unsigned N_VEC = 1 << N_IN;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ERR_W = N_IN + 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = N_IN'(N_VEC - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              fs_q, fs_d;

    // State and result registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fs_q    <= fs_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fs_d    = fs_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_HOLD;
                    vec_d   = '0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ff_d    = '0;
                    fs_d    = 1'b0;
                end
            end

            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Case inequality so an X/Z response counts as a mismatch
                    if (bus.Z !== EXPECT[vec_q]) begin
                        err_d = err_q + ERR_W'(1);
                        if (!fs_q) begin
                            ff_d = vec_q;
                            fs_d = 1'b1;
                        end
                    end
                    if (vec_q != VEC_LAST) begin
                        vec_d = vec_q + N_IN'(1);
                        cnt_d = CNT_LOAD;
                    end else begin
                        // Final vector: PASS uses the count including this sample
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.VEC        = vec_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.PASS       = pass_q;
    assign bus.ERR_COUNT  = err_q;
    assign bus.FIRST_FAIL = ff_q;
    assign bus.FAIL_SEEN  = fs_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomised scoreboard bench for truth_table_checker.
module tb_truth_table_checker;

    localparam int N_IN   = 3;
    localparam int N_VEC  = 8;
    localparam int SETTLE = 4;

    typedef enum int { M_GOLD, M_STUCK0, M_MASK } mode_t;

    typedef struct {
        int start;
        int done_cyc;
        int err;
        int ff;
        int fs;
        int pass;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET_N;
    mode_t      mode0;
    logic [7:0] mask0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       e0, e1;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    truth_table_checker_if #(.N_IN(N_IN)) bus0 ();
    truth_table_checker_if #(.N_IN(N_IN)) bus1 ();

    truth_table_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECT(8'hB7)) dut0 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus0)
    );

    truth_table_checker #(.N_IN(N_IN), .SETTLE(1), .EXPECT(8'hB7)) dut1 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus1)
    );

    // Reference gate function: Z = (A&B) ^ ~(B&C), {A,B,C} = vector
    function automatic logic ref_z(input int v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (a & b) ^ ~(b & c);
    endfunction

    // Circuit under test, optionally faulty
    function automatic logic circuit_z(input int v, input mode_t m, input logic [7:0] mk);
        if (m == M_STUCK0) return 1'b0;
        return ref_z(v) ^ mk[v];
    endfunction

    always_comb bus0.Z = circuit_z(int'(bus0.VEC), mode0, mask0);
    always_comb bus1.Z = ref_z(int'(bus1.VEC));

    // Expected sweep outcome from the circuit's behaviour over all vectors
    function automatic exp_t predict(input mode_t m, input logic [7:0] mk,
                                     input int s, input int settle);
        exp_t r;
        r.start = s;
        r.done_cyc = s + N_VEC * settle;
        r.err = 0;
        r.ff = 0;
        r.fs = 0;
        for (int i = 0; i < N_VEC; i++) begin
            if (circuit_z(i, m, mk) !== ref_z(i)) begin
                if (r.fs == 0) begin
                    r.ff = i;
                    r.fs = 1;
                end
                r.err++;
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on each DONE, tracks VEC stepping meanwhile
    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if (bus0.DONE) begin
                if (q0.size() == 0) begin
                    chk("done0_unexpected", 32'(bus0.DONE), 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    chk("done0_cycle", 32'(cyc), 32'(e0.done_cyc));
                    chk("err_count0", 32'(bus0.ERR_COUNT), 32'(e0.err));
                    chk("first_fail0", 32'(bus0.FIRST_FAIL), 32'(e0.ff));
                    chk("fail_seen0", 32'(bus0.FAIL_SEEN), 32'(e0.fs));
                    chk("pass0", 32'(bus0.PASS), 32'(e0.pass));
                    chk("busy0_at_done", 32'(bus0.BUSY), 32'd0);
                end
            end else if (bus0.BUSY && q0.size() > 0 && cyc >= q0[0].start) begin
                chk("vec0", 32'(bus0.VEC), 32'((cyc - q0[0].start) / SETTLE));
            end
            if (bus1.DONE) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", 32'(bus1.DONE), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("done1_cycle", 32'(cyc), 32'(e1.done_cyc));
                    chk("err_count1", 32'(bus1.ERR_COUNT), 32'(e1.err));
                    chk("pass1", 32'(bus1.PASS), 32'(e1.pass));
                end
            end
        end
    end

    task automatic start_sweep0(input bit push);
        bus0.START = 1'b1;
        if (push) q0.push_back(predict(mode0, mask0, cyc + 1, SETTLE));
        @(negedge CLK);
        bus0.START = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bus0.BUSY || bus1.BUSY) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 32'(n), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        int n;
        RESET_N    = 1'b0;
        bus0.START = 1'b1;
        bus1.START = 1'b0;
        mode0      = M_GOLD;
        mask0      = 8'h00;

        // Reset with START asserted
        repeat (3) @(negedge CLK);
        chk("rst_vec", 32'(bus0.VEC), 32'd0);
        chk("rst_busy", 32'(bus0.BUSY), 32'd0);
        chk("rst_done", 32'(bus0.DONE), 32'd0);
        chk("rst_pass", 32'(bus0.PASS), 32'd0);
        chk("rst_err", 32'(bus0.ERR_COUNT), 32'd0);
        chk("rst_ff", 32'(bus0.FIRST_FAIL), 32'd0);
        chk("rst_fs", 32'(bus0.FAIL_SEEN), 32'd0);
        bus0.START = 1'b0;
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_busy", 32'(bus0.BUSY), 32'd0);
        chk("idle_vec", 32'(bus0.VEC), 32'd0);

        // Golden, stuck-at-0, single inverted vector
        start_sweep0(1'b1);
        drain();
        mode0 = M_STUCK0;
        start_sweep0(1'b1);
        drain();
        mode0 = M_MASK;
        mask0 = 8'h40;
        start_sweep0(1'b1);
        drain();
        chk("hold_err", 32'(bus0.ERR_COUNT), 32'd1);
        chk("hold_ff", 32'(bus0.FIRST_FAIL), 32'd6);

        // Random fault patterns
        for (int k = 0; k < 6; k++) begin
            mask0 = 8'($urandom);
            start_sweep0(1'b1);
            drain();
        end

        // START mid-sweep is ignored
        mode0 = M_GOLD;
        mask0 = 8'h00;
        start_sweep0(1'b1);
        repeat (9) @(negedge CLK);
        bus0.START = 1'b1;
        @(negedge CLK);
        bus0.START = 1'b0;
        drain();

        // START held through DONE: back-to-back sweeps, results cleared
        mode0 = M_MASK;
        mask0 = 8'($urandom) | 8'h01;
        bus0.START = 1'b1;
        q0.push_back(predict(mode0, mask0, cyc + 1, SETTLE));
        q0.push_back(predict(mode0, mask0, cyc + 1 + N_VEC * SETTLE + 1, SETTLE));
        repeat (34) @(negedge CLK);
        bus0.START = 1'b0;
        chk("b2b_busy", 32'(bus0.BUSY), 32'd1);
        chk("b2b_err_clr", 32'(bus0.ERR_COUNT), 32'd0);
        chk("b2b_fs_clr", 32'(bus0.FAIL_SEEN), 32'd0);
        drain();

        // SETTLE=1 instance
        bus1.START = 1'b1;
        q1.push_back(predict(M_GOLD, 8'h00, cyc + 1, 1));
        @(negedge CLK);
        bus1.START = 1'b0;
        drain();

        // Asynchronous reset mid-sweep at VEC=3
        mode0 = M_STUCK0;
        start_sweep0(1'b0);
        n = 0;
        while (bus0.VEC != 3'd3 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_vec3", 32'(bus0.VEC), 32'd3);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_vec", 32'(bus0.VEC), 32'd0);
        chk("mid_rst_busy", 32'(bus0.BUSY), 32'd0);
        chk("mid_rst_err", 32'(bus0.ERR_COUNT), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (40) @(negedge CLK);
        chk("post_rst_busy", 32'(bus0.BUSY), 32'd0);

        // Recovery sweep
        mode0 = M_GOLD;
        start_sweep0(1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
